// File: rtl/regfile_write_queue_pkg.sv
// regfile_write_queue_pkg: shared register file widths, zero register and write-entry type
package regfile_write_queue_pkg;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 32;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [REG_DATA_WIDTH-1:0] data;
  } wr_entry_t;
endpackage

// File: rtl/regfile_bypass_lookup.sv
// regfile_bypass_lookup: youngest valid entry matching a nonzero read address
module regfile_bypass_lookup
  import regfile_write_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0]                  head,
  input  logic [DEPTH-1:0]                  valid,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0]  addrs,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0]  datas,
  input  logic [ADDR_WIDTH-1:0]             rd_addr,
  output logic                              hit,
  output logic [DATA_WIDTH-1:0]             data
);
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic m;
    hit = 1'b0;
    data = '0;
    idx = head;
    m = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      m = valid[idx] && addrs[idx] == rd_addr && rd_addr != ADDR_WIDTH'(REG_ZERO);
      hit = hit | m;
      data = m ? datas[idx] : data;
    end
  end
endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order register write buffer with read-port forwarding
module regfile_write_queue
  import regfile_write_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  wr_stall,
  output logic                  wr_enable,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic                  rd_hit_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic                  rd_hit_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic push, pop;
  assign empty = count_q == '0;
  assign count = count_q;
  assign in_ready = count_q != CNT_W'(DEPTH);
  assign wr_enable = !empty && !wr_stall;
  assign wr_addr = empty ? '0 : addr_q[head_q];
  assign wr_data = empty ? '0 : data_q[head_q];
  assign push = in_valid && in_ready && in_addr != ADDR_WIDTH'(REG_ZERO);
  assign pop = wr_enable;
  always_comb begin
    head_d = head_q + PTR_W'(pop);
    tail_d = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    valid_d = valid_q;
    addr_d = addr_q;
    data_d = data_q;
    if (pop) valid_d[head_q] = 1'b0;
    if (push) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q] = in_addr;
      data_d[tail_q] = in_data;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      valid_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  regfile_bypass_lookup #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lookup_a (
    .head(head_q), .valid(valid_q), .addrs(addr_q), .datas(data_q),
    .rd_addr(rd_addr_a), .hit(rd_hit_a), .data(rd_data_a)
  );
  regfile_bypass_lookup #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lookup_b (
    .head(head_q), .valid(valid_q), .addrs(addr_q), .datas(data_q),
    .rd_addr(rd_addr_b), .hit(rd_hit_b), .data(rd_data_b)
  );
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed self-checking bench for the register write queue
module tb_regfile_write_queue;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [4:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic wr_stall = 1'b0;
  logic wr_enable;
  logic [4:0] wr_addr;
  logic [31:0] wr_data;
  logic [4:0] rd_addr_a = '0;
  logic rd_hit_a;
  logic [31:0] rd_data_a;
  logic [4:0] rd_addr_b = '0;
  logic rd_hit_b;
  logic [31:0] rd_data_b;
  logic empty;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  regfile_write_queue dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wr_stall(wr_stall), .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_hit_a(rd_hit_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_hit_b(rd_hit_b), .rd_data_b(rd_data_b),
    .empty(empty), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    step();
    step();
    chk("rst_wr_enable", wr_enable, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_hit_a", rd_hit_a, 0);
    chk("rst_hit_b", rd_hit_b, 0);
    reset_n = 1'b1;
    step();
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hDEADBEEF;
    step();
    in_valid = 1'b0; rd_addr_a = 5'd5;
    #1;
    chk("t1_wr_enable", wr_enable, 1);
    chk("t1_wr_addr", wr_addr, 5);
    chk("t1_wr_data", wr_data, 32'hDEADBEEF);
    chk("t1_count", count, 1);
    chk("t1_retire_hit", rd_hit_a, 1);
    chk("t1_retire_data", rd_data_a, 32'hDEADBEEF);
    step();
    chk("t1_empty", empty, 1);
    chk("t1_count_after", count, 0);
    chk("t1_hit_gone", rd_hit_a, 0);
    wr_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_addr = 5'(i); in_data = 32'h100 + 32'(i);
      step();
    end
    in_addr = 5'd9; in_data = 32'h999;
    #1;
    chk("t2_count_full", count, 4);
    chk("t2_in_ready", in_ready, 0);
    chk("t2_wr_enable", wr_enable, 0);
    step();
    in_valid = 1'b0;
    chk("t2_count_hold", count, 4);
    chk("t2_head_hold", wr_addr, 1);
    wr_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t2_ret_en", wr_enable, 1);
      chk("t2_ret_addr", wr_addr, 5'(i));
      chk("t2_ret_data", wr_data, 32'h100 + 32'(i));
      step();
    end
    chk("t2_drained", empty, 1);
    chk("t2_no_fifth", wr_enable, 0);
    wr_stall = 1'b1;
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    in_valid = 1'b1; in_addr = 5'd8; in_data = 32'h33;
    rd_addr_a = 5'd7; rd_addr_b = 5'd8;
    #1;
    chk("t3_hit_a", rd_hit_a, 1);
    chk("t3_data_a", rd_data_a, 32'h22);
    chk("t3_hit_b_in_not_fwd", rd_hit_b, 0);
    chk("t3_data_b", rd_data_b, 0);
    in_valid = 1'b0;
    wr_stall = 1'b0;
    #1;
    chk("t3_ret1_addr", wr_addr, 7);
    chk("t3_ret1_data", wr_data, 32'h11);
    step();
    chk("t3_ret2_data", wr_data, 32'h22);
    chk("t3_hit_a_late", rd_data_a, 32'h22);
    step();
    chk("t3_empty", empty, 1);
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFFFFFF; rd_addr_a = 5'd0;
    #1;
    chk("t4_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    #1;
    chk("t4_count", count, 0);
    chk("t4_wr_enable", wr_enable, 0);
    chk("t4_hit_a", rd_hit_a, 0);
    step();
    chk("t4_wr_enable_late", wr_enable, 0);
    wr_stall = 1'b1;
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1; in_addr = 5'(j + 1); in_data = 32'h500 + 32'(j);
      step();
    end
    wr_stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_addr = 5'(k + 3); in_data = 32'h502 + 32'(k);
      #1;
      chk("t5_count", count, 2);
      chk("t5_addr", wr_addr, 5'(k + 1));
      chk("t5_data", wr_data, 32'h500 + 32'(k));
      step();
    end
    in_valid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      #1;
      chk("t5_tail_data", wr_data, 32'h500 + 32'(k));
      step();
    end
    chk("t5_empty", empty, 1);
    wr_stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; in_addr = 5'(20 + j); in_data = 32'h700 + 32'(j);
      step();
    end
    in_valid = 1'b0;
    chk("t6_count3", count, 3);
    #2;
    wr_stall = 1'b0; reset_n = 1'b0; rd_addr_a = 5'd20;
    #1;
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_wr_enable", wr_enable, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_hit_a", rd_hit_a, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("t6_post_en", wr_enable, 0);
    chk("t6_post_empty", empty, 1);
    step();
    chk("t6_post_en2", wr_enable, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
